// File: rtl/cpu_types_pkg.sv
// Shared execute-stage types: ALU/mul-div operation encoding and the mul/div FSM states.
// Encodings 14 and 15 are unused and treated as illegal operations by the ALU.
package cpu_types_pkg;

    typedef enum logic [3:0] {
        SLL   = 4'd0,
        SRL   = 4'd1,
        ADD   = 4'd2,
        SUB   = 4'd3,
        AND   = 4'd4,
        OR    = 4'd5,
        XOR   = 4'd6,
        NOR   = 4'd7,
        SLT   = 4'd8,
        SLTU  = 4'd9,
        MULT  = 4'd10,
        MULTU = 4'd11,
        DIV   = 4'd12,
        DIVU  = 4'd13
    } alu_md_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } alu_md_state_t;

    function automatic logic is_muldiv(input alu_md_op_t op);
        return (op == MULT) || (op == MULTU) || (op == DIV) || (op == DIVU);
    endfunction

endpackage

// File: rtl/alu_muldiv_if.sv
// Request/response bundle between decode, the ALU/mul-div block and its consumer.
// Valid/ready on both sides; the consumer holds the result by keeping out_ready low.
interface alu_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] operand1;
    logic [WIDTH-1:0] operand2;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             zero;
    logic             negative;
    logic             overflow;
    logic             div_by_zero;

    modport master (
        output in_valid, op, operand1, operand2, out_ready,
        input  in_ready, out_valid, result, hi, lo, zero, negative, overflow, div_by_zero
    );

    modport slave (
        input  in_valid, op, operand1, operand2, out_ready,
        output in_ready, out_valid, result, hi, lo, zero, negative, overflow, div_by_zero
    );

endinterface

// File: rtl/muldiv_iter.sv
// Unsigned shift-add multiplier / restoring divider, BPC bits per cycle, WIDTH/BPC cycles.
// No backpressure: start_i loads operands and the counter, iteration runs until it hits 0.
module muldiv_iter #(
    parameter int WIDTH = 32,
    parameter int BPC   = 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               div_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               last_o,
    output logic [2*WIDTH-1:0] acc_o
);

    localparam int ITERS = WIDTH / BPC;
    localparam int CW    = $clog2(ITERS + 1);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   m_q;
    logic               div_q;
    logic [CW-1:0]      cnt_q;
    logic [WIDTH:0]     part;
    logic [WIDTH:0]     diff;

    // acc holds {partial product, multiplier} or {remainder, quotient/dividend}
    always_comb begin
        acc_d = acc_q;
        part  = '0;
        diff  = '0;
        for (int i = 0; i < BPC; i++) begin
            if (div_q) begin
                part  = acc_d[2*WIDTH-1:WIDTH-1];
                diff  = part - {1'b0, m_q};
                acc_d = {acc_d[2*WIDTH-2:0], 1'b0};
                if (!diff[WIDTH]) begin
                    acc_d[2*WIDTH-1:WIDTH] = diff[WIDTH-1:0];
                    acc_d[0]               = 1'b1;
                end else begin
                    acc_d[2*WIDTH-1:WIDTH] = part[WIDTH-1:0];
                end
            end else begin
                part  = {1'b0, acc_d[2*WIDTH-1:WIDTH]} + (acc_d[0] ? {1'b0, m_q} : '0);
                acc_d = {part, acc_d[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q <= '0;
            m_q   <= '0;
            div_q <= 1'b0;
            cnt_q <= '0;
        end else if (start_i) begin
            acc_q <= {{WIDTH{1'b0}}, (div_i ? a_i : b_i)};
            m_q   <= div_i ? b_i : a_i;
            div_q <= div_i;
            cnt_q <= CW'(ITERS);
        end else if (cnt_q != '0) begin
            acc_q <= acc_d;
            cnt_q <= cnt_q - CW'(1);
        end
    end

    assign last_o = (cnt_q == CW'(1));
    assign acc_o  = acc_d;

endmodule

// File: rtl/alu_muldiv.sv
// Execute-stage ALU with iterative mul/div: basic ops 1 cycle, mul/div WIDTH/BPC+1 cycles.
// in_ready only in IDLE; a finished result is held until out_ready.
module alu_muldiv
    import cpu_types_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int BPC   = 1
) (
    input logic         CLK,
    input logic         RST,
    alu_muldiv_if.slave bus
);

    localparam int SW = $clog2(WIDTH);

    alu_md_state_t      state_q, state_d;
    logic [WIDTH-1:0]   result_q, result_d, hi_q, hi_d, lo_q, lo_d, a1_q, a1_d;
    logic               zero_q, zero_d, neg_q, neg_d, ovf_q, ovf_d, dbz_q, dbz_d;
    logic               md_div_q, md_div_d, neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d;
    logic               dbz_pend_q, dbz_pend_d;

    alu_md_op_t         op;
    logic [WIDTH-1:0]   a, b, add_r, sub_r, basic_res, a_mag, b_mag, fix_hi, fix_lo;
    logic               basic_ovf, md_op, md_signed, md_div, a_neg, b_neg, md_start, md_last;
    logic [2*WIDTH-1:0] md_acc, md_prod;

    assign op    = alu_md_op_t'(bus.op);
    assign a     = bus.operand1;
    assign b     = bus.operand2;
    assign add_r = a + b;
    assign sub_r = a - b;

    always_comb begin
        basic_res = '0;
        basic_ovf = 1'b0;
        case (op)
            SLL:  basic_res = b << a[SW-1:0];
            SRL:  basic_res = b >> a[SW-1:0];
            ADD: begin
                basic_res = add_r;
                basic_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (add_r[WIDTH-1] != a[WIDTH-1]);
            end
            SUB: begin
                basic_res = sub_r;
                basic_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (sub_r[WIDTH-1] != a[WIDTH-1]);
            end
            AND:  basic_res = a & b;
            OR:   basic_res = a | b;
            XOR:  basic_res = a ^ b;
            NOR:  basic_res = ~(a | b);
            SLT:  basic_res = WIDTH'($signed(a) < $signed(b));
            SLTU: basic_res = WIDTH'(a < b);
            default: basic_res = '0;
        endcase
    end

    // The iterator only ever sees magnitudes; signs are re-applied on completion
    assign md_op     = is_muldiv(op);
    assign md_signed = (op == MULT) || (op == DIV);
    assign md_div    = (op == DIV) || (op == DIVU);
    assign a_neg     = md_signed && a[WIDTH-1];
    assign b_neg     = md_signed && b[WIDTH-1];
    assign a_mag     = a_neg ? -a : a;
    assign b_mag     = b_neg ? -b : b;
    assign md_start  = (state_q == IDLE) && bus.in_valid && md_op;

    muldiv_iter #(
        .WIDTH (WIDTH),
        .BPC   (BPC)
    ) u_iter (
        .clk_i   (CLK),
        .rst_i   (RST),
        .start_i (md_start),
        .div_i   (md_div),
        .a_i     (a_mag),
        .b_i     (b_mag),
        .last_o  (md_last),
        .acc_o   (md_acc)
    );

    assign md_prod = neg_lo_q ? -md_acc : md_acc;

    always_comb begin
        fix_hi = md_prod[2*WIDTH-1:WIDTH];
        fix_lo = md_prod[WIDTH-1:0];
        if (md_div_q) begin
            if (dbz_pend_q) begin
                fix_lo = '1;
                fix_hi = a1_q;
            end else begin
                fix_lo = neg_lo_q ? -md_acc[WIDTH-1:0] : md_acc[WIDTH-1:0];
                fix_hi = neg_hi_q ? -md_acc[2*WIDTH-1:WIDTH] : md_acc[2*WIDTH-1:WIDTH];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        result_d   = result_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        a1_d       = a1_q;
        zero_d     = zero_q;
        neg_d      = neg_q;
        ovf_d      = ovf_q;
        dbz_d      = dbz_q;
        md_div_d   = md_div_q;
        neg_lo_d   = neg_lo_q;
        neg_hi_d   = neg_hi_q;
        dbz_pend_d = dbz_pend_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a1_d = a;
                    if (md_op) begin
                        state_d    = BUSY;
                        md_div_d   = md_div;
                        neg_lo_d   = a_neg ^ b_neg;
                        neg_hi_d   = a_neg;
                        dbz_pend_d = md_div && (b == '0);
                    end else begin
                        state_d  = DONE;
                        result_d = basic_res;
                        zero_d   = (basic_res == '0);
                        neg_d    = basic_res[WIDTH-1];
                        ovf_d    = basic_ovf;
                        dbz_d    = 1'b0;
                    end
                end
            end
            BUSY: begin
                if (md_last) begin
                    state_d  = DONE;
                    hi_d     = fix_hi;
                    lo_d     = fix_lo;
                    result_d = fix_lo;
                    zero_d   = (fix_lo == '0);
                    neg_d    = fix_lo[WIDTH-1];
                    ovf_d    = 1'b0;
                    dbz_d    = dbz_pend_q;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            result_q   <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            a1_q       <= '0;
            zero_q     <= 1'b0;
            neg_q      <= 1'b0;
            ovf_q      <= 1'b0;
            dbz_q      <= 1'b0;
            md_div_q   <= 1'b0;
            neg_lo_q   <= 1'b0;
            neg_hi_q   <= 1'b0;
            dbz_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            result_q   <= result_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            a1_q       <= a1_d;
            zero_q     <= zero_d;
            neg_q      <= neg_d;
            ovf_q      <= ovf_d;
            dbz_q      <= dbz_d;
            md_div_q   <= md_div_d;
            neg_lo_q   <= neg_lo_d;
            neg_hi_q   <= neg_hi_d;
            dbz_pend_q <= dbz_pend_d;
        end
    end

    assign bus.in_ready    = (state_q == IDLE);
    assign bus.out_valid   = (state_q == DONE);
    assign bus.result      = result_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
    assign bus.zero        = zero_q;
    assign bus.negative    = neg_q;
    assign bus.overflow    = ovf_q;
    assign bus.div_by_zero = dbz_q;

endmodule

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
- Parametrised successor to the single-cycle datapath ALU.
- Adds iterative signed/unsigned multiply and divide with HI/LO result registers.
- Registers all results behind a valid/ready handshake; sits in the execute stage.
- Decode stalls the pipeline while in_ready is low.

Parameters:
WIDTH, 32, operand/result width; must be even and at least 8
BPC, 1, bits retired per iteration cycle by mul/div; legal values 1, 2, 4; must divide WIDTH

Ports:
CLK  input  1  clock, rising edge
RST  input  1  synchronous reset, active-high
in_valid  input  1  request present
in_ready  output  1  block can accept a request
op  input  4  alu_md_op_t operation
operand1  input  WIDTH  A operand; shift amount for SLL/SRL
operand2  input  WIDTH  B operand; shifted value for SLL/SRL
out_valid  output  1  result valid
out_ready  input  1  consumer takes result
result  output  WIDTH  primary result
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register
zero  output  1  result == 0
negative  output  1  result[WIDTH-1]
overflow  output  1  signed overflow, ADD/SUB only
div_by_zero  output  1  DIV/DIVU with operand2 == 0

Behaviour:
- States: IDLE, BUSY, DONE.
- in_ready = (state == IDLE). Accept occurs when in_valid && in_ready.

IDLE:
- On accept of a basic op, the result, flags and operands are registered and the block moves to DONE.
- out_valid rises on the next cycle (latency 1).
- On accept of MULT/MULTU/DIV/DIVU: load operands and set iteration counter = WIDTH/BPC, then go to BUSY.
- Signed mul/div iterates on magnitudes and stores the final signs.

BUSY:
- Retires BPC bits per cycle and decrements the counter.
- When the counter reaches 0: apply sign fix-up, write hi/lo, go to DONE.
- Total latency from accept to out_valid = WIDTH/BPC + 1 cycles (33 for the defaults).
- in_valid is ignored while BUSY.

DONE:
- out_valid = 1. result and flags are held stable until out_ready.
- out_ready returns to IDLE. There is no back-to-back accept in the same cycle.

Basic ops:
- ADD, SUB: wrap modulo 2^WIDTH.
- AND, OR, XOR.
- NOR is bitwise ~(A|B).
- SLL/SRL: operand2 shifted by operand1[$clog2(WIDTH)-1:0].
- SLT: signed compare; SLTU: unsigned compare. Both produce 1 or 0.

Overflow:
- ADD: A and B have the same sign and the result sign differs.
- SUB: A and B have different signs and the result sign differs from A.
- 0 for all other ops.

MULT/MULTU:
- {hi, lo} = full 2*WIDTH product.
- result = lo.

DIV/DIVU:
- lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
- result = lo.

Divide corner cases:
- operand2 == 0: lo = all ones, hi = operand1, div_by_zero = 1.
- Signed MIN / -1: lo = MIN, hi = 0, overflow = 0.

Register persistence:
- hi/lo change only when a mul/div completes. Basic ops leave them unchanged.
- zero/negative are computed on result for every op.

Reset:
- Takes effect on the CLK edge where RST = 1. State returns to IDLE; out_valid, result, hi, lo, flags and counter go to 0.
- A reset during BUSY or DONE discards the operation. in_ready = 1 on the first cycle after RST deasserts.

Illegal op encodings:
- Complete in 1 cycle with result = 0, all flags = 0 except zero = 1.

Decomposition:
- cpu_types_pkg gains alu_md_op_t as a 4-bit enum: SLL, SRL, ADD, SUB, AND, OR, XOR, NOR, SLT, SLTU, MULT, MULTU, DIV, DIVU.
- cpu_types_pkg also gains an alu_md_state_t enum with IDLE, BUSY, DONE.
- One sub-module, muldiv_iter (WIDTH, BPC), holds the shift-add/restoring-divide datapath and counter.
- The parent owns the FSM, the basic ops, the handshake and the hi/lo registers.

Test Plan:
- ADD 0x7FFFFFFF + 0x00000001, out_ready held 1 -> out_valid one cycle after accept; result 0x80000000, overflow 1, negative 1, zero 0.
- SUB 0x80000000 - 0x00000001 -> result 0x7FFFFFFF, overflow 1. SLT 0xFFFFFFFF,0x00000001 -> 1. SLTU on the same operands -> 0.
- MULT 0xFFFFFFFE x 0x00000003 (BPC=1) -> out_valid 33 cycles after accept; hi 0xFFFFFFFF, lo 0xFFFFFFFA. in_ready = 0 throughout; a new in_valid pulse mid-operation is ignored.
- DIV -7 / 2 -> lo 0xFFFFFFFD, hi 0xFFFFFFFF. DIVU 7 / 0 -> lo 0xFFFFFFFF, hi 7, div_by_zero 1. DIV 0x80000000 / 0xFFFFFFFF -> lo 0x80000000, hi 0.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF with out_ready held 0 for 5 cycles after out_valid -> result/hi/lo stable (hi 0xFFFFFFFE, lo 0x00000001). A following ADD 1+1 leaves hi/lo unchanged.
- Assert RST mid-DIV (cycle 10 of BUSY) -> next cycle state IDLE, out_valid 0, hi = lo = 0, in_ready 1. Repeat MULT with BPC=4 -> latency 9 cycles, same product.
